// File: rtl/blink_pkg.sv
// Shared constants for the LED blink link.
// Used by both ends: the blink generator that toggles the LED line and
// blink_period_meter, which measures it on the receiving side.
//   meter_state_t        : meter FSM encoding (ST_IDLE / ST_MEASURE)
//   CLK_HZ               : system clock frequency
//   BLINK_TOGGLE_CYCLES  : clk cycles between generator toggles (1 Hz blink)
package blink_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_t;

  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned BLINK_TOGGLE_CYCLES = CLK_HZ / 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser plus edge detector for a slow asynchronous 1-bit input.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   async_in  : input asynchronous to clk
//   level     : synchronised level (last synchroniser stage)
//   rise/fall : combinational single-cycle edge strobes derived from level
// async_in reaches level after SYNC_STAGES clk edges; an edge strobe is
// therefore consumed by a downstream register on edge SYNC_STAGES+1.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period and high time of a slow periodic signal (e.g. a blinking
// LED line) in clk cycles; one report per full signal cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sig_in     : measured signal, asynchronous to clk
//   period     : clk cycles between the last two accepted rising edges
//   high_time  : clk cycles the signal was high within that period
//   valid      : one-cycle strobe, period/high_time updated this cycle
//   no_signal  : 1 = no measurement yet, or TIMEOUT cycles without a rise
//   meas_cnt   : count of accepted measurements (wraps)
// Handshake: valid is a pure strobe with no back-pressure; the consumer must
// capture period/high_time on the cycle valid is high (they stay stable
// until the next valid or a timeout clears them).
// The first rise after reset or timeout only arms the meter; every later
// rise closes one period. cnt is cleared on a rise and never exceeds
// TIMEOUT, so neither counter can overflow.
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 32'd249_999_999,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             no_signal,
  output logic [15:0]      meas_cnt
);

  // A period of TIMEOUT+1 is reportable, so it must fit in CNT_W bits.
  if ((CNT_W < 33) && ((64'd1 << CNT_W) <= (64'(TIMEOUT) + 64'd1))) begin : g_bad_timeout
    $error("blink_period_meter: TIMEOUT+1 does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic level;
  logic rise;
  logic unused_fall;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(sig_in),
    .level   (level),
    .rise    (rise),
    .fall    (unused_fall)
  );

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_d, high_time_d;
  logic             valid_d, no_signal_d;
  logic [15:0]      meas_cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period;
    high_time_d = high_time;
    valid_d     = 1'b0;
    no_signal_d = no_signal;
    meas_cnt_d  = meas_cnt;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (rise) begin
          // Arm only: the rise cycle itself is the first high cycle.
          state_d = ST_MEASURE;
          hcnt_d  = ONE_C;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          // cnt counts cycles since the previous rise minus one, hence +1.
          period_d    = cnt_q + ONE_C;
          high_time_d = hcnt_q;
          valid_d     = 1'b1;
          no_signal_d = 1'b0;
          meas_cnt_d  = meas_cnt + 16'd1;
          cnt_d       = '0;
          hcnt_d      = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d     = ST_IDLE;
          no_signal_d = 1'b1;
          period_d    = '0;
          high_time_d = '0;
          cnt_d       = '0;
          hcnt_d      = '0;
        end else begin
          cnt_d  = cnt_q + ONE_C;
          hcnt_d = hcnt_q + CNT_W'(level);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b1;
      meas_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period    <= period_d;
      high_time <= high_time_d;
      valid     <= valid_d;
      no_signal <= no_signal_d;
      meas_cnt  <= meas_cnt_d;
    end
  end

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter with TIMEOUT=99, SYNC_STAGES=2.
// The stimulus side predicts each report ({period, high_time}) at the rise
// that closes a period and queues it; a negedge monitor pops and compares
// whenever the DUT strobes valid.
module tb_blink_period_meter;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 99;
  localparam int W       = 2 * CNT_W;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             no_signal;
  logic [15:0]      meas_cnt;

  blink_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .no_signal(no_signal),
    .meas_cnt (meas_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int           checks   = 0;
  int           failures = 0;
  logic         armed    = 1'b0;
  int           last_h   = 0;
  int           last_l   = 0;
  int           exp_meas = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_nosig"}, 32'(no_signal), 1);
    check({tag, "_meas"}, 32'(meas_cnt), 0);
  endtask

  // ---------------- driver tasks ----------------
  // Each call starts and ends 1 time unit after a rising clk edge.
  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model of one rising edge: it closes the previous h/l period if the meter
  // was armed and that period did not exceed TIMEOUT+1 cycles.
  task automatic note_rise(input int h, input int l);
    if (armed && (last_h + last_l <= TIMEOUT + 1)) begin
      exp_q.push_back({32'(last_h + last_l), 32'(last_h)});
      exp_meas++;
    end
    armed  = 1'b1;
    last_h = h;
    last_l = l;
  endtask

  task automatic period_wave(input int h, input int l);
    note_rise(h, l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(valid), 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", period, mon_e[W-1:CNT_W]);
        check("high_time", high_time, mon_e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst    = 1'b1;
    sig_in = 1'b0;

    // 1: reset held while sig_in toggles
    repeat (6) begin
      @(posedge clk);
      #1 sig_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_reset_vals("rst");
    end
    @(posedge clk);
    #1 sig_in = 1'b0;
    rst = 1'b0;
    hold(1'b0, 5);
    check("idle_nosig", 32'(no_signal), 1);

    // 2: 10 high / 10 low, 5 periods -> 4 reports
    repeat (5) period_wave(10, 10);
    check("sq_meas", 32'(meas_cnt), 4);
    check("sq_nosig", 32'(no_signal), 0);
    check("sq_drained", 32'(exp_q.size()), 0);

    // 3: duty changes
    period_wave(3, 17);
    period_wave(1, 39);

    // 4: rise then no more edges -> timeout 100 cycles after the rise
    note_rise(0, 0);
    sig_in = 1'b1;
    wait_valid("to_valid", 20);
    @(negedge clk);
    check("valid_one_cycle", 32'(valid), 0);
    n = 1;
    while (!no_signal && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_gap", 32'(n), 100);
    check("to_period", period, 0);
    check("to_high", high_time, 0);
    check("to_meas", 32'(meas_cnt), 7);
    armed = 1'b0;
    @(posedge clk);
    #1;
    hold(1'b0, 10);
    period_wave(10, 10);
    check("rearm_nosig", 32'(no_signal), 1);

    // 5: period of exactly TIMEOUT+1 is accepted; TIMEOUT+2 times out
    period_wave(30, 70);
    period_wave(5, 5);
    check("coinc_nosig", 32'(no_signal), 0);
    period_wave(30, 71);
    period_wave(10, 10);
    check("over_nosig", 32'(no_signal), 1);
    check("over_period", period, 0);
    check("over_meas", 32'(meas_cnt), 32'(exp_meas));

    // 6: reset in the middle of a high phase, sig_in stays high
    note_rise(8, 0);
    hold(1'b1, 8);
    #1 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("mid_rst");
    end
    armed    = 1'b0;
    exp_meas = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    period_wave(10, 10);
    check("rel_nosig", 32'(no_signal), 1);
    period_wave(10, 10);
    period_wave(4, 6);
    period_wave(1, 10);
    hold(1'b0, 5);
    check("end_drained", 32'(exp_q.size()), 0);
    check("end_meas", 32'(meas_cnt), 32'(exp_meas));
    check("end_nosig", 32'(no_signal), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
